// File: rtl/write_back.sv
// Write-back pipeline register plus a 32-entry architectural register file
// with two combinational read ports. `WB_BYPASS_EN forwards MW_* and WB_* to the reads.
module write_back #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] MW_ALUout,
  input  logic [ADDR_W-1:0] MW_RD,
  input  logic              MW_WE,
  input  logic [ADDR_W-1:0] RS,
  input  logic [ADDR_W-1:0] RT,
  output logic [DATA_W-1:0] RS_DATA,
  output logic [DATA_W-1:0] RT_DATA,
  output logic              WB_VALID,
  output logic [ADDR_W-1:0] WB_RD,
  output logic [DATA_W-1:0] WB_DATA,
  output logic [31:0]       WB_COUNT
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] rf_q, rf_d;
  logic                         wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0]            wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]            wb_data_q, wb_data_d;
  logic [31:0]                  wb_count_q, wb_count_d;
  logic                         commit;

  // r0 never commits, so the array slot stays 0 and the count ignores it.
  assign commit = wb_valid_q && (wb_rd_q != '0);

  always_comb begin
    wb_valid_d = MW_WE;
    wb_rd_d    = MW_RD;
    wb_data_d  = MW_ALUout;
    rf_d       = rf_q;
    wb_count_d = wb_count_q;
    if (commit) begin
      rf_d[wb_rd_q] = wb_data_q;
      if (wb_count_q != 32'hFFFF_FFFF) wb_count_d = wb_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_count_q <= '0;
      rf_q       <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_count_q <= wb_count_d;
      rf_q       <= rf_d;
    end
  end

  logic [1:0][ADDR_W-1:0] rd_idx;
  assign rd_idx = {RT, RS};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [DATA_W-1:0] data;
    always_comb begin
      data = '0;
      if (rd_idx[p] != '0) begin
`ifdef WB_BYPASS_EN
        // Newest value wins: memory-stage result, then pending WB, then array.
        if (MW_WE && (MW_RD == rd_idx[p]))               data = MW_ALUout;
        else if (wb_valid_q && (wb_rd_q == rd_idx[p]))   data = wb_data_q;
        else                                             data = rf_q[rd_idx[p]];
`else
        data = rf_q[rd_idx[p]];
`endif
      end
    end
  end

  assign RS_DATA  = g_rd[0].data;
  assign RT_DATA  = g_rd[1].data;
  assign WB_VALID = wb_valid_q;
  assign WB_RD    = wb_rd_q;
  assign WB_DATA  = wb_data_q;
  assign WB_COUNT = wb_count_q;
endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back; expected values follow the build's bypass setting.
module tb_write_back;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] MW_ALUout;
  logic [4:0]  MW_RD;
  logic        MW_WE;
  logic [4:0]  RS, RT;
  logic [31:0] RS_DATA, RT_DATA, WB_DATA, WB_COUNT;
  logic        WB_VALID;
  logic [4:0]  WB_RD;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  write_back dut (
    .clk(clk), .rst(rst), .MW_ALUout(MW_ALUout), .MW_RD(MW_RD), .MW_WE(MW_WE),
    .RS(RS), .RT(RT), .RS_DATA(RS_DATA), .RT_DATA(RT_DATA),
    .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_DATA(WB_DATA), .WB_COUNT(WB_COUNT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d);
    MW_WE = we; MW_RD = rd; MW_ALUout = d;
  endtask

  initial begin
    rst = 1'b1; drive(1'b0, 5'd0, 32'd0); RS = 5'd0; RT = 5'd0;
    tick(); rst = 1'b0;

    // Some writes, then two cycles of reset must wipe them.
    drive(1'b1, 5'd1, 32'h0000_0101); tick();
    drive(1'b1, 5'd2, 32'h0000_0202); tick();
    drive(1'b1, 5'd3, 32'h0000_0303); tick();
    drive(1'b0, 5'd0, 32'd0); rst = 1'b1; tick(); tick();
    RS = 5'd1; RT = 5'd2; #1;
    chk("rst_rs",    RS_DATA, 32'd0);
    chk("rst_rt",    RT_DATA, 32'd0);
    chk("rst_valid", {31'd0, WB_VALID}, 32'd0);
    chk("rst_wbrd",  {27'd0, WB_RD}, 32'd0);
    chk("rst_wbdat", WB_DATA, 32'd0);
    chk("rst_count", WB_COUNT, 32'd0);
    rst = 1'b0;

    // Basic write to r5.
    tick();
    drive(1'b1, 5'd5, 32'h1234_5678); RS = 5'd5; RT = 5'd0; #1;
    chk("basic_c0", RS_DATA, BYP ? 32'h1234_5678 : 32'd0);
    chk("basic_rt0", RT_DATA, 32'd0);
    tick(); drive(1'b0, 5'd0, 32'd0); #1;
    chk("basic_c1", RS_DATA, BYP ? 32'h1234_5678 : 32'd0);
    chk("basic_valid1", {31'd0, WB_VALID}, 32'd1);
    chk("basic_wbrd1", {27'd0, WB_RD}, 32'd5);
    chk("basic_wbdat1", WB_DATA, 32'h1234_5678);
    chk("basic_cnt1", WB_COUNT, 32'd0);
    tick(); #1;
    chk("basic_c2", RS_DATA, 32'h1234_5678);
    chk("basic_cnt2", WB_COUNT, 32'd1);
    chk("basic_valid2", {31'd0, WB_VALID}, 32'd0);

    // r0 write travels through WB but never commits.
    tick(); drive(1'b1, 5'd0, 32'hDEAD_BEEF); RS = 5'd0; #1;
    chk("r0_c0", RS_DATA, 32'd0);
    tick(); drive(1'b0, 5'd0, 32'd0); #1;
    chk("r0_c1", RS_DATA, 32'd0);
    chk("r0_valid1", {31'd0, WB_VALID}, 32'd1);
    chk("r0_wbdat1", WB_DATA, 32'hDEAD_BEEF);
    tick(); #1;
    chk("r0_c2", RS_DATA, 32'd0);
    chk("r0_valid2", {31'd0, WB_VALID}, 32'd0);
    chk("r0_cnt", WB_COUNT, 32'd1);

    // Back-to-back writes to r7; later value wins.
    tick(); drive(1'b1, 5'd7, 32'h11); RT = 5'd7; RS = 5'd7; #1;
    chk("pri_c0", RT_DATA, BYP ? 32'h11 : 32'd0);
    tick(); drive(1'b1, 5'd7, 32'h22); #1;
    chk("pri_c1", RT_DATA, BYP ? 32'h22 : 32'd0);
    tick(); drive(1'b0, 5'd0, 32'd0); #1;
    chk("pri_c2", RT_DATA, BYP ? 32'h22 : 32'h11);
    chk("pri_rs_eq_rt", RS_DATA, BYP ? 32'h22 : 32'h11);
    tick(); #1;
    chk("pri_c3", RT_DATA, 32'h22);
    chk("pri_cnt", WB_COUNT, 32'd3);

    // Top index r31 with all-ones data; r5 must be untouched.
    tick(); drive(1'b1, 5'd31, 32'hFFFF_FFFF); RS = 5'd31; RT = 5'd5; #1;
    chk("r31_c0", RS_DATA, BYP ? 32'hFFFF_FFFF : 32'd0);
    tick(); drive(1'b0, 5'd0, 32'd0); tick(); #1;
    chk("r31_c2", RS_DATA, 32'hFFFF_FFFF);
    chk("r31_r5", RT_DATA, 32'h1234_5678);
    chk("r31_cnt", WB_COUNT, 32'd4);

    // Reset with a pending write in the WB register discards it.
    tick(); drive(1'b1, 5'd3, 32'hAA); RS = 5'd3; RT = 5'd7;
    tick(); drive(1'b0, 5'd0, 32'd0); rst = 1'b1; #1;
    chk("mid_valid", {31'd0, WB_VALID}, 32'd1);
    tick(); rst = 1'b0; #1;
    chk("mid_valid0", {31'd0, WB_VALID}, 32'd0);
    chk("mid_r3a", RS_DATA, 32'd0);
    chk("mid_cnt", WB_COUNT, 32'd0);
    tick(); #1;
    chk("mid_r3b", RS_DATA, 32'd0);
    chk("mid_r7", RT_DATA, 32'd0);

    // Saturation: preload the counter just below the top, then commit three writes.
    force dut.wb_count_q = 32'hFFFF_FFFE;
    #1 release dut.wb_count_q;
    #1 chk("sat_pre", WB_COUNT, 32'hFFFF_FFFE);
    drive(1'b1, 5'd1, 32'h1);
    tick(); drive(1'b1, 5'd2, 32'h2);
    tick(); drive(1'b1, 5'd3, 32'h3); #1;
    chk("sat_c1", WB_COUNT, 32'hFFFF_FFFF);
    tick(); drive(1'b0, 5'd0, 32'd0);
    tick(); tick(); #1;
    chk("sat_end", WB_COUNT, 32'hFFFF_FFFF);
    RS = 5'd3; RT = 5'd2; #1;
    chk("sat_r3", RS_DATA, 32'h3);
    chk("sat_r2", RT_DATA, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
